// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC initiator-side sequencer.
package mac_pkg;
  localparam int MAC_IN_W  = 32;
  localparam int MAC_OUT_W = 16;

  // EN=bit7, START=bit1, LOAD=bit0
  localparam logic [7:0] MAC_CTRL_IDLE  = 8'h80;
  localparam logic [7:0] MAC_CTRL_LOAD  = 8'h81;
  localparam logic [7:0] MAC_CTRL_START = 8'h83;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RESP
  } mac_state_e;
endpackage

// File: rtl/mac_wdog.sv
// Saturating 8-bit watchdog; expired flags the last permitted WAIT cycle.
module mac_wdog (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = 8'd0;
    else if (enable && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == limit - 8'd1);
endmodule

// File: rtl/mac_driver.sv
// Drives the MAC load/start handshake for one host command and returns
// either the captured result or a timeout over the response channel.
module mac_driver
  import mac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [MAC_IN_W-1:0]  cmd_a,
  input  logic [MAC_IN_W-1:0]  cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MAC_OUT_W-1:0] rsp_data,
  output logic                 rsp_timeout,
  output logic [MAC_IN_W-1:0]  MAC_INA,
  output logic [MAC_IN_W-1:0]  MAC_INB,
  output logic [7:0]           MAC_CTRL,
  input  logic [MAC_OUT_W-1:0] MAC_OUT,
  input  logic                 IRQ_MAC,
  output logic                 busy
);
  mac_state_e           state_q;
  logic [MAC_IN_W-1:0]  ina_q, inb_q;
  logic [MAC_OUT_W-1:0] data_q;
  logic [7:0]           ctrl_q;
  logic                 rdy_q, vld_q, tmo_q, busy_q;
  logic                 wd_expired;

  // Counter restarts from 0 on the first WAIT cycle because LOAD clears it.
  mac_wdog u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_LOAD),
    .enable  (state_q == ST_WAIT),
    .limit   (8'(TIMEOUT_CYCLES)),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ina_q   <= '0;
      inb_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= MAC_CTRL_IDLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          ina_q   <= cmd_a;
          inb_q   <= cmd_b;
          ctrl_q  <= MAC_CTRL_LOAD;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          ctrl_q  <= MAC_CTRL_START;
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (IRQ_MAC || wd_expired) begin
          // A completion on the watchdog's last cycle still counts as a result.
          data_q  <= IRQ_MAC ? MAC_OUT : '0;
          tmo_q   <= !IRQ_MAC;
          vld_q   <= 1'b1;
          ctrl_q  <= MAC_CTRL_IDLE;
          state_q <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = rdy_q;
  assign rsp_valid   = vld_q;
  assign rsp_data    = data_q;
  assign rsp_timeout = tmo_q;
  assign MAC_INA     = ina_q;
  assign MAC_INB     = inb_q;
  assign MAC_CTRL    = ctrl_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_mac_driver.sv
// Directed bench for mac_driver with a behavioural MAC raising IRQ a set
// number of cycles after START is first seen.
module tb_mac_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [15:0] rsp_data;
  logic [31:0] MAC_INA, MAC_INB;
  logic [7:0]  MAC_CTRL;
  logic [15:0] MAC_OUT = '0;
  logic        IRQ_MAC, busy;

  logic        irq_en = 1'b0, irq_force = 1'b0;
  logic [7:0]  lat = 8'd0, m_cnt = 8'd0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mac_driver #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .MAC_INA(MAC_INA), .MAC_INB(MAC_INB), .MAC_CTRL(MAC_CTRL),
    .MAC_OUT(MAC_OUT), .IRQ_MAC(IRQ_MAC), .busy(busy)
  );

  // MAC model: m_cnt counts START cycles, IRQ on the lat-th one after the first.
  always @(posedge clk) m_cnt <= (MAC_CTRL == 8'h83) ? m_cnt + 8'd1 : 8'd0;
  assign IRQ_MAC = irq_force | (irq_en && MAC_CTRL == 8'h83 && m_cnt == lat);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    for (int i = 0; i < max && !rsp_valid; i++) step();
    chk("rsp_wait", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, {24'd0, MAC_CTRL}, 32'h80);
    chk({tag, "_ina"}, MAC_INA, 32'd0);
    chk({tag, "_inb"}, MAC_INB, 32'd0);
    chk({tag, "_rvld"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rdat"}, {16'd0, rsp_data}, 32'd0);
    chk({tag, "_rtmo"}, {31'd0, rsp_timeout}, 32'd0);
    chk({tag, "_crdy"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Eight START cycles then a response: used by timeout and race cases.
  task automatic run_eight(input string tag, input logic [15:0] exp_d, input logic exp_t);
    send(32'h1111_2222, 32'h3333_4444);
    chk({tag, "_load"}, {24'd0, MAC_CTRL}, 32'h81);
    for (int i = 0; i < 8; i++) begin
      step();
      chk({tag, "_start"}, {24'd0, MAC_CTRL}, 32'h83);
      chk({tag, "_novld"}, {31'd0, rsp_valid}, 32'd0);
    end
    step();
    chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_ctrl"}, {24'd0, MAC_CTRL}, 32'h80);
    chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp_d});
    chk({tag, "_tmo"}, {31'd0, rsp_timeout}, {31'd0, exp_t});
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    step();
    reset = 1'b1;
    step();
    chk_reset_vals("idle");

    // IRQ in IDLE must not start anything
    irq_force = 1'b1; step(); step(); irq_force = 1'b0;
    chk("idle_irq_vld", {31'd0, rsp_valid}, 32'd0);
    chk("idle_irq_busy", {31'd0, busy}, 32'd0);

    // Basic transaction
    irq_en = 1'b1; lat = 8'd5; MAC_OUT = 16'h1234;
    send(32'h56CE_D903, 32'hC3CC_D903);
    chk("b_load", {24'd0, MAC_CTRL}, 32'h81);
    chk("b_crdy", {31'd0, cmd_ready}, 32'd0);
    chk("b_busy", {31'd0, busy}, 32'd1);
    chk("b_ina", MAC_INA, 32'h56CE_D903);
    chk("b_inb", MAC_INB, 32'hC3CC_D903);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b_start", {24'd0, MAC_CTRL}, 32'h83);
      chk("b_novld", {31'd0, rsp_valid}, 32'd0);
      chk("b_irq", {31'd0, IRQ_MAC}, (i == 5) ? 32'd1 : 32'd0);
    end
    step();
    chk("b_idlectl", {24'd0, MAC_CTRL}, 32'h80);
    chk("b_vld", {31'd0, rsp_valid}, 32'd1);
    chk("b_data", {16'd0, rsp_data}, 32'h1234);
    chk("b_tmo", {31'd0, rsp_timeout}, 32'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("b_vld_drop", {31'd0, rsp_valid}, 32'd0);
    chk("b_crdy_back", {31'd0, cmd_ready}, 32'd1);
    chk("b_busy_off", {31'd0, busy}, 32'd0);
    chk("b_ina_hold", MAC_INA, 32'h56CE_D903);

    // Backpressure: response held, second command refused
    lat = 8'd2; MAC_OUT = 16'hA5C3;
    send(32'hDEAD_0001, 32'hBEEF_0002);
    wait_rsp(20);
    MAC_OUT = 16'h0F0F;
    cmd_a = 32'h9999_9999; cmd_b = 32'h8888_8888; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_vld", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {16'd0, rsp_data}, 32'hA5C3);
      chk("bp_crdy", {31'd0, cmd_ready}, 32'd0);
      chk("bp_ina", MAC_INA, 32'hDEAD_0001);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("bp_done", {31'd0, cmd_ready}, 32'd1);
    step();
    chk("bp_nocmd", {24'd0, MAC_CTRL}, 32'h80);

    // Timeout: IRQ never comes
    irq_en = 1'b0;
    run_eight("to", 16'h0000, 1'b1);

    // Race: IRQ on the 8th WAIT cycle wins over the watchdog
    irq_en = 1'b1; lat = 8'd7; MAC_OUT = 16'hBEEF;
    run_eight("race", 16'hBEEF, 1'b0);

    // Reset during WAIT, then recover
    lat = 8'd20;
    send(32'h0BAD_F00D, 32'h1234_5678);
    step(); step();
    chk("rw_inwait", {24'd0, MAC_CTRL}, 32'h83);
    #2 reset = 1'b0; #1;
    chk_reset_vals("rw");
    step();
    reset = 1'b1;
    step();
    chk_reset_vals("rw_rel");
    lat = 8'd3; MAC_OUT = 16'h7E57;
    send(32'h0000_0005, 32'h0000_0007);
    chk("rw_ina", MAC_INA, 32'h0000_0005);
    wait_rsp(20);
    chk("rw_data", {16'd0, rsp_data}, 32'h7E57);
    chk("rw_tmo", {31'd0, rsp_timeout}, 32'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("rw_done", {31'd0, cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
